// File: rtl/alu_unit.sv
// alu_unit: per-thread GPU ALU computing ADD/SUB/MUL/DIV or an NZP compare word,
// registered on alu_out only while the thread is enabled in the EXECUTE state.
module alu_unit #(
  parameter int DATA_BITS = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [2:0]           core_state,
  input  logic [1:0]           decoded_alu_arithmetic_mux,
  input  logic                 decoded_alu_output_mux,
  input  logic [DATA_BITS-1:0] rs,
  input  logic [DATA_BITS-1:0] rt,
  output logic [DATA_BITS-1:0] alu_out
);
  localparam logic [2:0] EXECUTE = 3'b101;
  logic [DATA_BITS-1:0] sum, diff, prod, quot, arith, cmp;
  always_comb begin
    sum   = rs + rt;
    diff  = rs - rt;
    prod  = rs * rt;
    quot  = (rt == '0) ? '1 : rs / rt;
    arith = decoded_alu_arithmetic_mux[1] ? (decoded_alu_arithmetic_mux[0] ? quot : prod)
                                          : (decoded_alu_arithmetic_mux[0] ? diff : sum);
    cmp   = {{(DATA_BITS-3){1'b0}}, rs > rt, rs == rt, rs < rt};
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) alu_out <= '0;
    else if (enable && core_state == EXECUTE) alu_out <= decoded_alu_output_mux ? cmp : arith;
endmodule

// File: tb/tb_alu_unit.sv
// tb_alu_unit: directed and random checks of alu_unit against an arithmetic model.
module tb_alu_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic [2:0]  core_state = 3'b101;
  logic [1:0]  amux = 2'd0;
  logic        omux = 1'b0;
  logic [15:0] rs = 16'd5;
  logic [15:0] rt = 16'd3;
  logic [15:0] alu_out;
  logic [15:0] exp_out = 16'd0;
  logic        chk_on = 1'b0;
  int          n_checks = 0;
  int          n_fail = 0;

  alu_unit #(.DATA_BITS(16)) dut (
    .clk(clk), .reset(reset), .enable(enable), .core_state(core_state),
    .decoded_alu_arithmetic_mux(amux), .decoded_alu_output_mux(omux),
    .rs(rs), .rt(rt), .alu_out(alu_out)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] model(input logic [1:0] op, input logic cmpsel,
                                        input int unsigned a, input int unsigned b);
    longint unsigned r;
    if (cmpsel) r = (a > b) ? 4 : (a == b) ? 2 : 1;
    else if (op == 2'd0) r = (a + b) % 65536;
    else if (op == 2'd1) r = (a + 65536 - b) % 65536;
    else if (op == 2'd2) r = (longint'(a) * longint'(b)) % 65536;
    else r = (b == 0) ? 65535 : a / b;
    return 16'(r);
  endfunction

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", name, got, want, $time);
    end
  endtask

  task automatic step(input logic en, input logic [2:0] st, input logic [1:0] op,
                      input logic cs, input logic [15:0] a, input logic [15:0] b);
    enable = en; core_state = st; amux = op; omux = cs; rs = a; rt = b;
    @(posedge clk);
    if (reset) exp_out = 16'd0;
    else if (en && st == 3'b101) exp_out = model(op, cs, a, b);
    #1;
  endtask

  always @(negedge clk)
    if (chk_on) check("model", alu_out, exp_out);

  initial begin
    #2;
    check("reset_zero", alu_out, 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    chk_on = 1'b1;
    step(1, 3'b101, 2'd0, 0, 16'd5, 16'd3);
    check("first_add", alu_out, 16'd8);
    step(1, 3'b101, 2'd0, 0, 16'hFFFF, 16'd2);
    check("add_wrap", alu_out, 16'h0001);
    step(1, 3'b101, 2'd1, 0, 16'd3, 16'd5);
    check("sub_wrap", alu_out, 16'hFFFE);
    step(1, 3'b101, 2'd2, 0, 16'h0100, 16'h0100);
    check("mul_ovf", alu_out, 16'h0000);
    step(1, 3'b101, 2'd2, 0, 16'd300, 16'd200);
    check("mul_low", alu_out, 16'hEA60);
    step(1, 3'b101, 2'd3, 0, 16'd100, 16'd7);
    check("div", alu_out, 16'd14);
    step(1, 3'b101, 2'd3, 0, 16'd9, 16'd0);
    check("div_zero", alu_out, 16'hFFFF);
    step(1, 3'b101, 2'd2, 1, 16'd7, 16'd3);
    check("cmp_p", alu_out, 16'h0004);
    step(1, 3'b101, 2'd1, 1, 16'd9, 16'd9);
    check("cmp_z", alu_out, 16'h0002);
    step(1, 3'b101, 2'd0, 1, 16'd2, 16'hFFFF);
    check("cmp_n", alu_out, 16'h0001);
    step(1, 3'b101, 2'd0, 0, 16'd5, 16'd3);
    for (int i = 0; i < 3; i++) step(1, 3'b110, 2'd2, 0, 16'd40, 16'd2);
    check("hold_update", alu_out, 16'd8);
    for (int i = 0; i < 3; i++) step(0, 3'b101, 2'd1, 1, 16'd1, 16'd77);
    check("hold_disabled", alu_out, 16'd8);
    for (int st = 0; st < 8; st++)
      if (st != 5) step(1, 3'(st), 2'd3, 0, 16'd1000, 16'd3);
    check("hold_states", alu_out, 16'd8);
    #2;
    reset = 1'b1;
    exp_out = 16'd0;
    #1;
    check("async_reset", alu_out, 16'h0000);
    step(1, 3'b101, 2'd0, 0, 16'd11, 16'd22);
    check("reset_hold", alu_out, 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 1000; i++)
      step(($urandom_range(0, 7) != 0),
           ($urandom_range(0, 5) != 0) ? 3'b101 : 3'($urandom_range(0, 7)),
           2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 9) == 0) ? rt : 16'($urandom),
           ($urandom_range(0, 9) == 0) ? 16'd0 : 16'($urandom));
    @(negedge clk);
    chk_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
